sprite_scheduler: RTL

- Per-scanline sprite scheduler and arbiter for the shared 8x8 sprite lookup, which is a combinational block taking 3-bit sx/sy and a 4-bit code and returning 4-bit R/G/B.
- During horizontal blanking it scans the moving-sprite table (Pac-Man plus ghosts) and selects up to MAX_PER_LINE sprites that intersect the next line.
- During active video it time-multiplexes the lookup between the selected sprite and the background tile over two clocks per pixel, then composites the two results.
- It sits between the VGA timing/tile-map logic and the pixel output register.

---
 rtl/sprite_pkg.sv | 32 +++
 rtl/sprite_line_eval.sv | 115 +++++++++++
 rtl/sprite_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and sizing for the per-scanline sprite scheduler.
// Holds table/slot dimensions, the slot payload, RGB triple and the
// line-evaluation FSM state encoding.
package sprite_pkg;

    localparam int unsigned NUM_SPRITES  = 5;
    localparam int unsigned MAX_PER_LINE = 4;
    localparam int unsigned COORD_W      = 10;
    localparam int unsigned SPRITE_SIZE  = 8;
    localparam int unsigned IDX_W        = $clog2(NUM_SPRITES);

    // One scheduled sprite for a scanline
    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [2:0]         row;
        logic [3:0]         code;
    } slot_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } eval_state_e;

endpackage

// File: rtl/sprite_line_eval.sv
// Horizontal-blank sprite evaluation: walks the sprite table one entry
// per clk after line_start and fills the shadow slots with the sprites
// that intersect the upcoming line.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   line_start      start (or restart) a scan for next_y
//   next_y          y of the upcoming line, valid with line_start
//   spr_en/x/y/code packed sprite table
//   shadow_slots    slots selected for the upcoming line
//   line_overflow   pulses on the last scan clk if hits exceeded the slots
module sprite_line_eval
    import sprite_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           line_start,
    input  logic [COORD_W-1:0]             next_y,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
    input  logic [NUM_SPRITES*4-1:0]       spr_code,
    output slot_t [MAX_PER_LINE-1:0]       shadow_slots,
    output logic                           line_overflow
);

    eval_state_e                   state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [COORD_W-1:0]            y_q, y_d;
    slot_t [MAX_PER_LINE-1:0]      slot_q, slot_d;
    logic                          ovf_q, ovf_d;

    logic [COORD_W-1:0]            x_arr    [NUM_SPRITES];
    logic [COORD_W-1:0]            y_arr    [NUM_SPRITES];
    logic [3:0]                    code_arr [NUM_SPRITES];
    logic [COORD_W-1:0]            dy;
    logic                          hit;
    logic                          stored;

    // Unpack the flat sprite table
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            x_arr[i]    = spr_x[i*COORD_W +: COORD_W];
            y_arr[i]    = spr_y[i*COORD_W +: COORD_W];
            code_arr[i] = spr_code[i*4 +: 4];
        end
    end

    // Next-state and slot fill
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        y_d           = y_q;
        slot_d        = slot_q;
        ovf_d         = ovf_q;
        line_overflow = 1'b0;
        stored        = 1'b0;
        // Modulo subtraction also catches sprites wrapping past the top
        dy            = y_q - y_arr[idx_q];
        hit           = spr_en[idx_q] && (dy < COORD_W'(SPRITE_SIZE));

        if (line_start) begin
            state_d = SCAN;
            y_d     = next_y;
            slot_d  = '0;
            idx_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (hit) begin
                        for (int s = 0; s < MAX_PER_LINE; s++) begin
                            if (!stored && !slot_q[s].valid) begin
                                slot_d[s].valid = 1'b1;
                                slot_d[s].x     = x_arr[idx_q];
                                slot_d[s].row   = dy[2:0];
                                slot_d[s].code  = code_arr[idx_q];
                                stored          = 1'b1;
                            end
                        end
                        if (!stored) begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
                        state_d       = DONE;
                        line_overflow = ovf_d;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            y_q     <= '0;
            slot_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            slot_q  <= slot_d;
            ovf_q   <= ovf_d;
        end
    end

    assign shadow_slots = slot_q;

endmodule

// File: rtl/sprite_scheduler.sv
// Per-scanline sprite scheduler and lookup arbiter. Evaluation fills
// shadow slots during blanking; at de rise they become the active slots.
// Each pixel uses two clks: phase A looks up the winning sprite, phase B
// looks up the background tile, then the pair is composited (black
// sprite pixels are transparent).
// Ports:
//   clk, rst_n              clock (2x pixel rate), sync active-low reset
//   pix_ce, de              pixel strobe (phase A) and active video
//   scr_x, scr_y            current pixel coordinates
//   line_start, next_y      start sprite evaluation for the next line
//   bg_code                 background tile code for the current pixel
//   spr_en/x/y/code         packed sprite table
//   map_sx/sy/code          to the shared 8x8 lookup
//   map_r/g/b               from the shared 8x8 lookup
//   pix_r/g/b, pix_valid    composited pixel, one clk per pixel
//   line_overflow           too many sprites on the evaluated line
module sprite_scheduler
    import sprite_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pix_ce,
    input  logic                           de,
    input  logic [COORD_W-1:0]             scr_x,
    input  logic [COORD_W-1:0]             scr_y,
    input  logic                           line_start,
    input  logic [COORD_W-1:0]             next_y,
    input  logic [3:0]                     bg_code,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
    input  logic [NUM_SPRITES*4-1:0]       spr_code,
    output logic [2:0]                     map_sx,
    output logic [2:0]                     map_sy,
    output logic [3:0]                     map_code,
    input  logic [3:0]                     map_r,
    input  logic [3:0]                     map_g,
    input  logic [3:0]                     map_b,
    output logic [3:0]                     pix_r,
    output logic [3:0]                     pix_g,
    output logic [3:0]                     pix_b,
    output logic                           pix_valid,
    output logic                           line_overflow
);

    slot_t [MAX_PER_LINE-1:0] shadow_slots;
    slot_t [MAX_PER_LINE-1:0] act_q, act_d;
    slot_t [MAX_PER_LINE-1:0] slots_c;
    logic                     de_prev_q, de_prev_d;
    logic                     armed_q, armed_d;
    logic                     live_q, live_d;
    logic                     phase_b_q, phase_b_d;
    logic                     spr_hit_q, spr_hit_d;
    rgb_t                     spr_rgb_q, spr_rgb_d;
    rgb_t                     pix_q, pix_d;
    logic                     pix_valid_q, pix_valid_d;
    logic [2:0]               px_q, px_d;

    rgb_t                     map_rgb;
    logic                     de_rise;
    logic                     phase_a;
    logic                     hit;
    logic [COORD_W-1:0]       dx;
    logic [2:0]               hit_sx;
    logic [2:0]               hit_row;
    logic [3:0]               hit_code;
    logic                     unused_scr_y_hi;

    assign unused_scr_y_hi = ^scr_y[COORD_W-1:3];

    sprite_line_eval u_eval (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_start    (line_start),
        .next_y        (next_y),
        .spr_en        (spr_en),
        .spr_x         (spr_x),
        .spr_y         (spr_y),
        .spr_code      (spr_code),
        .shadow_slots  (shadow_slots),
        .line_overflow (line_overflow)
    );

    // Phase tracking, arbitration, lookup muxing and compositing
    always_comb begin
        map_rgb.r   = map_r;
        map_rgb.g   = map_g;
        map_rgb.b   = map_b;
        de_prev_d   = pix_ce ? de : de_prev_q;
        de_rise     = pix_ce && de && !de_prev_q;
        // The first pixel of a line must already see the new slot set
        slots_c     = de_rise ? shadow_slots : act_q;
        act_d       = slots_c;
        armed_d     = armed_q | line_start;
        live_d      = live_q;
        if (de_rise) begin
            live_d = armed_q;
        end else if (pix_ce && !de) begin
            live_d = 1'b0;
        end
        // Pixels are only produced on a line that followed a line_start
        phase_a     = pix_ce && de && (de_rise ? armed_q : live_q);
        phase_b_d   = phase_a;
        px_d        = phase_a ? scr_x[2:0] : px_q;

        hit         = 1'b0;
        dx          = '0;
        hit_sx      = '0;
        hit_row     = '0;
        hit_code    = '0;
        for (int s = 0; s < MAX_PER_LINE; s++) begin
            dx = scr_x - slots_c[s].x;
            if (!hit && slots_c[s].valid && (dx < COORD_W'(SPRITE_SIZE))) begin
                hit      = 1'b1;
                hit_sx   = dx[2:0];
                hit_row  = slots_c[s].row;
                hit_code = slots_c[s].code;
            end
        end

        map_sx      = '0;
        map_sy      = '0;
        map_code    = '0;
        spr_hit_d   = spr_hit_q;
        spr_rgb_d   = spr_rgb_q;
        pix_d       = '0;
        pix_valid_d = 1'b0;

        if (phase_a) begin
            if (hit) begin
                map_sx   = hit_sx;
                map_sy   = hit_row;
                map_code = hit_code;
            end else begin
                map_sx   = scr_x[2:0];
                map_sy   = scr_y[2:0];
                map_code = bg_code;
            end
            spr_hit_d = hit;
            spr_rgb_d = hit ? map_rgb : '0;
        end else if (phase_b_q) begin
            map_sx      = px_q;
            map_sy      = scr_y[2:0];
            map_code    = bg_code;
            pix_valid_d = 1'b1;
            pix_d       = (spr_hit_q && (spr_rgb_q != '0)) ? spr_rgb_q : map_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q       <= '0;
            de_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
            live_q      <= 1'b0;
            phase_b_q   <= 1'b0;
            spr_hit_q   <= 1'b0;
            spr_rgb_q   <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            px_q        <= '0;
        end else begin
            act_q       <= act_d;
            de_prev_q   <= de_prev_d;
            armed_q     <= armed_d;
            live_q      <= live_d;
            phase_b_q   <= phase_b_d;
            spr_hit_q   <= spr_hit_d;
            spr_rgb_q   <= spr_rgb_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            px_q        <= px_d;
        end
    end

    assign pix_r     = pix_q.r;
    assign pix_g     = pix_q.g;
    assign pix_b     = pix_q.b;
    assign pix_valid = pix_valid_q;

endmodule
